// File: rtl/mul_if.sv
// Request/response bundle for mul_unit: valid/ready request side, valid/ready result side, abort.
interface mul_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] c;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, c
  );
endinterface

// File: rtl/mul_unit.sv
// RV64M shift-add multiplier; result valid XLEN/STEP (MULW: 32/STEP) cycles after accept.
// One op in flight; the result is held in DONE until out_ready, and flush drops it from any state.
module mul_unit #(
  parameter int XLEN = 64,
  parameter int STEP = 1
) (
  input logic clk,
  input logic resetn,
  mul_if.slave io
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int N_FULL = XLEN / STEP;
  localparam int N_W    = 32 / STEP;
  localparam int CW     = $clog2(N_FULL) + 1;

  state_t            state, state_nxt;
  logic [2*XLEN-1:0] mcand, prod, acc_sum, prod_fin;
  logic [XLEN-1:0]   mplier, c_q, c_sel;
  logic [CW-1:0]     count;
  logic              neg, hi_q, w_q;

  logic              accept, is_w_in, hi_in, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic signed [31:0] lo32;

  assign accept  = (state == IDLE) && io.in_valid && !io.flush;
  assign is_w_in = (io.op == 3'd4) && (XLEN == 64);
  assign hi_in   = (io.op == 3'd1) || (io.op == 3'd2) || (io.op == 3'd3);
  assign a_neg   = ((io.op == 3'd1) || (io.op == 3'd2)) && io.a[XLEN-1];
  assign b_neg   = (io.op == 3'd1) && io.b[XLEN-1];

  // The most-negative operand negates to itself, which read unsigned is its true magnitude.
  always_comb begin
    a_mag = a_neg ? (~io.a + 1'b1) : io.a;
    b_mag = b_neg ? (~io.b + 1'b1) : io.b;
    if (is_w_in) begin
      a_mag = XLEN'(io.a[31:0]);
      b_mag = XLEN'(io.b[31:0]);
    end
  end

  always_comb begin
    acc_sum = prod;
    for (int i = 0; i < STEP; i++) begin
      if (mplier[i]) acc_sum = acc_sum + (mcand << i);
    end
    prod_fin = neg ? (~acc_sum + 1'b1) : acc_sum;
    lo32     = prod_fin[31:0];
    if (w_q)       c_sel = XLEN'(lo32);
    else if (hi_q) c_sel = prod_fin[2*XLEN-1:XLEN];
    else           c_sel = prod_fin[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (count == CW'(1)) state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (io.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      count  <= '0;
      neg    <= 1'b0;
      hi_q   <= 1'b0;
      w_q    <= 1'b0;
      c_q    <= '0;
    end else if (accept) begin
      mcand  <= (2*XLEN)'(a_mag);
      mplier <= b_mag;
      prod   <= '0;
      count  <= is_w_in ? CW'(N_W) : CW'(N_FULL);
      neg    <= a_neg ^ b_neg;
      hi_q   <= hi_in;
      w_q    <= is_w_in;
    end else if (state == BUSY && !io.flush) begin
      prod   <= acc_sum;
      mcand  <= mcand << STEP;
      mplier <= mplier >> STEP;
      count  <= count - CW'(1);
      // Sign fix happens on the same edge that enters DONE.
      if (count == CW'(1)) c_q <= c_sel;
    end
  end

  assign io.in_ready  = (state == IDLE) && resetn;
  assign io.out_valid = (state == DONE);
  assign io.c         = c_q;
endmodule

// File: tb/tb_mul_unit.sv
// Randomized scoreboard bench for mul_unit against a wide-arithmetic reference model.
module tb_mul_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rnd_bp = 1'b0;
  bit   prev_ov = 1'b0;

  typedef struct {
    logic [63:0] c;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  mul_if #(.XLEN(64)) mi ();
  mul_if #(.XLEN(64)) m4 ();

  mul_unit #(.XLEN(64), .STEP(1)) dut (.clk(clk), .resetn(resetn), .io(mi));
  mul_unit #(.XLEN(64), .STEP(4)) dut4 (.clk(clk), .resetn(resetn), .io(m4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [63:0]  p32;
    case (op)
      3'd1: begin ea = {{64{a[63]}}, a}; eb = {{64{b[63]}}, b}; end
      3'd2: begin ea = {{64{a[63]}}, a}; eb = {64'd0, b}; end
      3'd3: begin ea = {64'd0, a}; eb = {64'd0, b}; end
      3'd4: begin
        p32 = {32'd0, a[31:0]} * {32'd0, b[31:0]};
        return {{32{p32[31]}}, p32[31:0]};
      end
      default: return a * b;
    endcase
    p = ea * eb;
    return p[127:64];
  endfunction

  // Scoreboard monitor: latency on the rising edge of out_valid, value every DONE cycle.
  always @(negedge clk) begin
    if (mi.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(mi.out_valid), 64'd0);
      end else begin
        if (!prev_ov) chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
        chk("result", mi.c, exp_q[0].c);
        chk("in_ready_in_done", 64'(mi.in_ready), 64'd0);
        if (mi.out_ready) void'(exp_q.pop_front());
      end
    end
    prev_ov = mi.out_valid;
  end

  always @(posedge clk) begin
    #1;
    if (rnd_bp) mi.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input bit push);
    bit   ok = 1'b0;
    exp_t e;
    @(posedge clk); #1;
    mi.op = op; mi.a = a; mi.b = b; mi.in_valid = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (mi.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    else if (push) begin
      e.c = ref_mul(op, a, b);
      e.lat = (op == 3'd4) ? 32 : 64;
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    mi.in_valid = 1'b0;
    mi.op = 3'($urandom); mi.a = {$urandom, $urandom}; mi.b = {$urandom, $urandom};
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic abort_case(input bit use_reset);
    send(3'd0, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    if (use_reset) resetn = 1'b0; else mi.flush = 1'b1;
    @(negedge clk);
    if (use_reset) chk("in_ready_during_reset", 64'(mi.in_ready), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1; mi.flush = 1'b0;
    @(negedge clk);
    chk(use_reset ? "reset_abort_out_valid" : "flush_abort_out_valid", 64'(mi.out_valid), 64'd0);
    chk(use_reset ? "reset_abort_in_ready" : "flush_abort_in_ready", 64'(mi.in_ready), 64'd1);
    repeat (80) @(negedge clk);
    send(3'd0, 64'd3, 64'd5, 1'b1);
    drain();
  endtask

  initial begin
    logic [63:0] a, b, c_hold, vals[6];
    int acc4, lat4;
    bit ok;
    vals[0] = 64'h0; vals[1] = 64'h1; vals[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    vals[3] = 64'h8000_0000_0000_0000; vals[4] = 64'h7FFF_FFFF_FFFF_FFFF; vals[5] = 64'h0000_0000_8000_0000;
    mi.flush = 1'b0; mi.in_valid = 1'b0; mi.op = 3'd0; mi.a = '0; mi.b = '0; mi.out_ready = 1'b1;
    m4.flush = 1'b0; m4.in_valid = 1'b0; m4.op = 3'd0; m4.a = '0; m4.b = '0; m4.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(mi.out_valid), 64'd0);
    chk("reset_in_ready", 64'(mi.in_ready), 64'd0);
    chk("reset_c", mi.c, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(mi.in_ready), 64'd1);

    send(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    send(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send(3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    send(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
    send(3'd4, 64'h1_0000_0002, 64'h4000_0000, 1'b1);
    send(3'd7, 64'd9, 64'd11, 1'b1);
    drain();

    // Backpressure: hold the result for 10 cycles.
    send(3'd0, 64'd100, 64'd200, 1'b1);
    mi.out_ready = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (mi.out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("bp_out_valid_timeout", 64'd0, 64'd1);
    c_hold = mi.c;
    chk("bp_result_value", c_hold, 64'd20000);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid_held", 64'(mi.out_valid), 64'd1);
      chk("bp_c_stable", mi.c, c_hold);
    end
    @(posedge clk); #1 mi.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 64'(mi.out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(mi.in_ready), 64'd1);
    drain();

    // flush with in_valid in IDLE is not an accept.
    @(posedge clk); #1 mi.flush = 1'b1; mi.in_valid = 1'b1;
    @(posedge clk); #1 mi.flush = 1'b0; mi.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_in_ready", 64'(mi.in_ready), 64'd1);

    abort_case(1'b0);
    abort_case(1'b1);

    // STEP=4 instance: MULW latency 8.
    @(posedge clk); #1;
    m4.op = 3'd4; m4.a = 64'h1_0000_0002; m4.b = 64'h4000_0000; m4.in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (m4.in_ready) begin ok = 1'b1; break; end
    end
    acc4 = cyc + 1;
    @(posedge clk); #1 m4.in_valid = 1'b0; m4.a = '1;
    ok = ok && 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (m4.out_valid) begin ok = 1'b1; break; end
    end
    lat4 = cyc - acc4;
    chk("step4_done_seen", 64'(ok), 64'd1);
    chk("step4_mulw_latency", 64'(lat4), 64'd8);
    chk("step4_mulw_result", m4.c, 64'hFFFF_FFFF_8000_0000);

    // Random traffic with random result backpressure; requests queue behind busy unit.
    rnd_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? vals[$urandom_range(0, 5)] : {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? vals[$urandom_range(0, 5)] : {$urandom, $urandom};
      send(3'($urandom_range(0, 7)), a, b, 1'b1);
    end
    drain();
    rnd_bp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
